// File: rtl/mwadd_seq_pkg.sv
// Shared constants and types for the multi-byte sequential adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mwadd_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte counter width; a single-byte operand still needs one counter bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mwadd_seq_cia8b.sv
// 8-bit carry-in adder; sum[8] carries the byte carry-out.
// Latency: combinational.
// Backpressure: none.
module cia8b
  import mwadd_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W:0]   sum,
  output logic              cout
);

  assign sum  = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign cout = sum[BYTE_W];

endmodule

// File: rtl/mwadd_seq.sv
// Sequential add/subtract of NBYTES-wide operands, one byte per cycle, LSB first.
// Latency: out_valid rises NBYTES+1 cycles after the accept cycle.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module mwadd_seq
  import mwadd_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] inA,
  input  logic [BYTE_W*NBYTES-1:0] inB,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     busy
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = cnt_width(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t            state, state_nxt;
  logic [W-1:0]      a_r, b_r, sum_r;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic [BYTE_W-1:0] a_byte, b_byte;
  logic [BYTE_W:0]   add_sum;
  logic              adder_cout_unused;
  logic              accept;

  assign accept = in_valid && (state == IDLE);

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: RUN lasts exactly NBYTES cycles, DONE waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (cnt == LAST)     state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state alone.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    begin out_valid = 1'b1; busy = 1'b1; end
      default: in_ready  = 1'b0;
    endcase
  end

  // Pick the operand bytes addressed by the byte counter.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (cnt == CW'(k)) begin
        a_byte = a_r[k*BYTE_W +: BYTE_W];
        b_byte = b_r[k*BYTE_W +: BYTE_W];
      end
    end
  end

  cia8b u_add (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .sum  (add_sum),
    .cout (adder_cout_unused)
  );

  // Operand capture on accept (B inverted, carry preset for subtract), then one byte per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_r   <= inA;
      b_r   <= sub ? ~inB : inB;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (cnt == CW'(k)) sum_r[k*BYTE_W +: BYTE_W] <= add_sum[BYTE_W-1:0];
      end
      carry <= add_sum[BYTE_W];
      cnt   <= cnt + 1'b1;
    end
  end

  assign sum  = sum_r;
  assign cout = carry;

endmodule

// File: tb/tb_mwadd_seq.sv
// Bench for mwadd_seq: directed corner cases plus random operations on NBYTES=4 and NBYTES=1.
// Latency: checks out_valid arrives NBYTES+1 cycles after accept.
// Backpressure: exercises out_ready stalls with ignored in_valid pulses.
module tb_mwadd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, busy;
  logic [31:0] inA, inB, sum;
  logic        s1_in_valid, s1_in_ready, s1_cin, s1_sub, s1_out_valid, s1_out_ready, s1_cout, s1_busy;
  logic [7:0]  s1_inA, s1_inB, s1_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mwadd_seq #(.NBYTES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  mwadd_seq #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .inA(s1_inA), .inB(s1_inB), .cin(s1_cin), .sub(s1_sub), .out_valid(s1_out_valid),
    .out_ready(s1_out_ready), .sum(s1_sum), .cout(s1_cout), .busy(s1_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the whole operand width.
  function automatic logic [32:0] ref_op(input int nb, input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic s);
    logic [63:0] m, aa, bb, r;
    m  = (64'd1 << (8 * nb)) - 64'd1;
    aa = {32'd0, a} & m;
    bb = {32'd0, b} & m;
    if (s) r = ((aa - bb) & m) | ((aa >= bb) ? (m + 64'd1) : 64'd0);
    else   r = aa + bb + {63'd0, ci};
    return {r[8*nb], r[31:0] & m[31:0]};
  endfunction

  // One operation on the 4-byte instance, with optional stall cycles in DONE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic s, input int stall);
    logic [32:0] exp;
    int lat;
    exp = ref_op(4, a, b, ci, s);
    chk({tag, "_in_ready"}, in_ready, 1);
    inA = a; inB = b; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    in_valid = 1'b0; inA = $urandom; inB = $urandom; cin = ~ci; sub = ~s;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_sum"}, sum, exp[31:0]);
    chk({tag, "_cout"}, cout, exp[32]);
    for (int k = 0; k < stall; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      inA = $urandom; inB = $urandom;
      @(negedge clk);
      chk({tag, "_hold_vld"}, out_valid, 1);
      chk({tag, "_hold_sum"}, sum, exp[31:0]);
      chk({tag, "_hold_cout"}, cout, exp[32]);
      chk({tag, "_hold_rdy"}, in_ready, 0);
    end
    // in_valid held through the handshake cycle must not start a new op.
    in_valid = (stall > 0);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk({tag, "_post_vld"}, out_valid, 0);
    chk({tag, "_post_busy"}, busy, 0);
    chk({tag, "_post_rdy"}, in_ready, 1);
    @(negedge clk);
    chk({tag, "_idle_sum"}, sum, exp[31:0]);
    chk({tag, "_idle_cout"}, cout, exp[32]);
  endtask

  // One operation on the single-byte instance.
  task automatic run_op1(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic s);
    logic [32:0] exp;
    int lat;
    exp = ref_op(1, {24'd0, a}, {24'd0, b}, ci, s);
    s1_inA = a; s1_inB = b; s1_cin = ci; s1_sub = s; s1_in_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    s1_in_valid = 1'b0; s1_inA = ~a; s1_inB = ~b;
    while (!s1_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_sum"}, s1_sum, exp[7:0]);
    chk({tag, "_cout"}, s1_cout, exp[32]);
    s1_out_ready = 1'b1;
    @(negedge clk);
    s1_out_ready = 1'b0;
    chk({tag, "_post_rdy"}, s1_in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; inA = '0; inB = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    s1_in_valid = 1'b0; s1_inA = '0; s1_inB = '0; s1_cin = 1'b0; s1_sub = 1'b0; s1_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    run_op("carry_byte", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0 | 1'b1, 0);
    run_op("sub_noborrow", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0);
    run_op("stall", 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 3);
    run_op("after_stall", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 0);

    // Reset while byte 2 is being processed.
    inA = 32'hFFFF_FFFF; inB = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_sum", sum, 0);
    chk("midrun_cout", cout, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_in_ready", in_ready, 1);
    @(negedge clk);
    chk("midrun_still_idle", busy, 0);

    for (int i = 0; i < 16; i++) begin
      run_op("rand4", $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    run_op1("nb1_8080", 8'h80, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_op1("rand1", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mwadd_seq.md
MWADD_SEQ -- requirements
Module: mwadd_seq

Interface
REQ-001 SHALL have parameter: NBYTES, 4, operand width in bytes (legal 1..16).
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  in  1  request carries valid operands.
REQ-005 SHALL have port: in_ready  out  1  block can accept a request.
REQ-006 SHALL have port: inA  in  8*NBYTES  operand A.
REQ-007 SHALL have port: inB  in  8*NBYTES  operand B.
REQ-008 SHALL have port: cin  in  1  carry-in (add mode only).
REQ-009 SHALL have port: sub  in  1  1 = compute inA - inB.
REQ-010 SHALL have port: out_valid  out  1  sum/cout hold a completed result.
REQ-011 SHALL have port: out_ready  in  1  consumer accepts result.
REQ-012 SHALL have port: sum  out  8*NBYTES  result.
REQ-013 SHALL have port: cout  out  1  carry-out of most significant byte.
REQ-014 SHALL have port: busy  out  1  high in RUN or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL assert in_ready only in IDLE, independent of in_valid.
REQ-017 SHALL, on in_valid && in_ready in IDLE, latch inA, inB (inverted when sub=1), initial carry (1 when sub=1, else cin), clear byte counter, enter RUN.
REQ-018 SHALL ignore inA/inB/cin/sub outside the accepting cycle.
REQ-019 SHALL in RUN process one byte per cycle, LSB first: byte k = A[k] + B[k] + carry via byte adder; result byte stored at sum position k; carry register takes adder bit 8.
REQ-020 SHALL leave RUN after exactly NBYTES cycles (counter reaches NBYTES-1) and enter DONE.
REQ-021 SHALL assert out_valid in DONE only; latency from accept edge to out_valid high = NBYTES+1 cycles.
REQ-022 SHALL drive cout = final carry register value; for sub, cout=1 means no borrow (inA >= inB unsigned).
REQ-023 SHALL hold sum, cout, out_valid stable while out_valid && !out_ready.
REQ-024 SHALL on out_valid && out_ready return to IDLE; no request accepted in that same cycle (throughput one op per NBYTES+2 cycles minimum).
REQ-025 SHALL keep sum/cout unchanged in IDLE after a completed transfer until the next accept.
REQ-026 SHALL wrap result modulo 2^(8*NBYTES); overflow only via cout.
REQ-027 SHALL size byte counter clog2(NBYTES) bits, minimum 1; NBYTES=1 gives exactly one RUN cycle.

Reset
REQ-028 SHALL, when rst_n=0 at a clock edge, force state IDLE, sum=0, cout=0, out_valid=0, busy=0, counter=0, carry=0; in_ready=1 the cycle after reset release.
REQ-029 SHALL, on reset mid-RUN or in DONE, discard the operation with no partial result presented.

Structure
REQ-030 SHALL place FSM state encodings (IDLE=0, RUN=1, DONE=2, 2 bits) and byte width constant 8 in the shared ALU package/header.
REQ-031 SHALL instantiate exactly one existing cia8b byte adder (carry-in = carry register; carry-out taken from its sum[8]; its cout port unused).
REQ-032 SHALL keep operand and result storage as shift registers (shift right 8 per RUN cycle) or byte-indexed registers; no other sub-modules.

Verification (NBYTES=4 unless stated)
REQ-033 SHALL cover: 0x000000FF + 0x00000001, cin=0 -> sum 0x00000100, cout 0, out_valid exactly 5 cycles after accept.
REQ-034 SHALL cover: 0xFFFFFFFF + 0x00000000, cin=1 -> sum 0x00000000, cout 1 (carry through all bytes).
REQ-035 SHALL cover: sub=1, 0x00000005 - 0x00000007 -> sum 0xFFFFFFFE, cout 0; 0x00000007 - 0x00000005 -> 0x00000002, cout 1.
REQ-036 SHALL cover: out_ready low 3 cycles in DONE -> sum/cout/out_valid stable, in_ready 0, in_valid pulses ignored; accept resumes the cycle after handshake.
REQ-037 SHALL cover: rst_n low during RUN byte 2 -> next cycle out_valid 0, sum 0, cout 0, busy 0, in_ready 1.
REQ-038 SHALL cover: NBYTES=1, 0x80 + 0x80, cin=0 -> sum 0x00, cout 1, latency 2 cycles.
